// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU issue path: opcodes, instruction
// field positions and the sequencer state encoding.
package cpu_pkg;

  localparam int DW = 8;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_MUL = 4'h2;
  localparam logic [3:0] OP_DIV = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_LDI = 4'h8;

  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int DST_MSB  = 11;
  localparam int DST_LSB  = 10;
  localparam int SRC1_MSB = 9;
  localparam int SRC1_LSB = 8;
  localparam int SRC2_MSB = 7;
  localparam int SRC2_LSB = 6;
  localparam int IMM_MSB  = 7;
  localparam int IMM_LSB  = 0;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RETIRE
  } state_e;

  // Codes 0..6 drive the ALU directly; 0111 is the one hole in the low half.
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op[3] == 1'b0) && (op[2:0] != 3'b111);
  endfunction

endpackage

// File: rtl/regfile4x8.sv
// Small register file: two source read ports, one debug read port and a
// single synchronous write port, cleared by the asynchronous reset.
module regfile4x8 #(
  parameter int NREGS = 4,
  parameter int DW    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(NREGS)-1:0] raddr1_i,
  input  logic [$clog2(NREGS)-1:0] raddr2_i,
  input  logic [$clog2(NREGS)-1:0] raddr3_i,
  input  logic                     we_i,
  input  logic [$clog2(NREGS)-1:0] waddr_i,
  input  logic [DW-1:0]            wdata_i,
  output logic [DW-1:0]            rdata1_o,
  output logic [DW-1:0]            rdata2_o,
  output logic [DW-1:0]            rdata3_o
);

  logic [DW-1:0] mem_q [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = mem_q[raddr1_i];
  assign rdata2_o = mem_q[raddr2_i];
  assign rdata3_o = mem_q[raddr3_i];

endmodule

// File: rtl/alu_sequencer.sv
// Issue-side controller for the external combinational ALU: accepts one
// instruction, presents registered operands, then writes back and retires.
module alu_sequencer
  import cpu_pkg::*;
#(
  parameter int NREGS = 4,
  parameter int DW    = cpu_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [15:0]   instr,
  output logic [DW-1:0] alu_operand1,
  output logic [DW-1:0] alu_operand2,
  output logic [2:0]    alu_operation,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_carry,
  output logic          done,
  output logic          error,
  output logic          carry_flag,
  output logic          zero_flag,
  input  logic [1:0]    rd_sel,
  output logic [DW-1:0] rd_data
);

  state_e        state_q, state_d;
  logic [3:0]    opcode_q, opcode_d;
  logic [1:0]    dst_q, dst_d;
  logic [DW-1:0] imm_q, imm_d;
  logic [DW-1:0] op1_q, op1_d;
  logic [DW-1:0] op2_q, op2_d;
  logic [2:0]    opn_q, opn_d;
  logic          carry_q, carry_d;
  logic          zero_q, zero_d;
  logic          done_q, done_d;
  logic          error_q, error_d;

  logic          we;
  logic [DW-1:0] wdata;
  logic [DW-1:0] src1_data, src2_data;

  regfile4x8 #(
    .NREGS (NREGS),
    .DW    (DW)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .raddr1_i (instr[SRC1_MSB:SRC1_LSB]),
    .raddr2_i (instr[SRC2_MSB:SRC2_LSB]),
    .raddr3_i (rd_sel),
    .we_i     (we),
    .waddr_i  (dst_q),
    .wdata_i  (wdata),
    .rdata1_o (src1_data),
    .rdata2_o (src2_data),
    .rdata3_o (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      opcode_q <= '0;
      dst_q    <= '0;
      imm_q    <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      opn_q    <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      dst_q    <= dst_d;
      imm_q    <= imm_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      opn_q    <= opn_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    dst_d    = dst_q;
    imm_d    = imm_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    opn_d    = opn_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    error_d  = 1'b0;
    we       = 1'b0;
    wdata    = alu_result;

    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          opcode_d = instr[OPC_MSB:OPC_LSB];
          dst_d    = instr[DST_MSB:DST_LSB];
          imm_d    = instr[IMM_MSB:IMM_LSB];
          op1_d    = src1_data;
          op2_d    = src2_data;
          opn_d    = instr[OPC_LSB+2:OPC_LSB];
          state_d  = EXEC;
        end
      end
      EXEC: begin
        state_d = RETIRE;
        // Divide-by-zero is judged on the latched operand the ALU actually sees.
        if (opcode_q == OP_LDI) begin
          we     = 1'b1;
          wdata  = imm_q;
          done_d = 1'b1;
        end else if (is_alu_op(opcode_q) && !((opcode_q == OP_DIV) && (op2_q == '0))) begin
          we      = 1'b1;
          done_d  = 1'b1;
          zero_d  = (alu_result == '0);
          carry_d = (opcode_q == OP_ADD) ? alu_carry : 1'b0;
        end else begin
          error_d = 1'b1;
        end
      end
      RETIRE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign instr_ready   = (state_q == IDLE);
  assign alu_operand1  = op1_q;
  assign alu_operand2  = op2_q;
  assign alu_operation = opn_q;
  assign done          = done_q;
  assign error         = error_q;
  assign carry_flag    = carry_q;
  assign zero_flag     = zero_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: provides a behavioural ALU, a transaction-level
// reference model, directed literal checks and a randomized instruction stream.
module tb_alu_sequencer;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [7:0]  alu_operand1;
  logic [7:0]  alu_operand2;
  logic [2:0]  alu_operation;
  logic [7:0]  alu_result;
  logic        alu_carry;
  logic        done;
  logic        error;
  logic        carry_flag;
  logic        zero_flag;
  logic [1:0]  rd_sel;
  logic [7:0]  rd_data;

  int testsRun = 0;
  int testsFailed = 0;
  int cycleCount = 0;

  alu_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .alu_operand1  (alu_operand1),
    .alu_operand2  (alu_operand2),
    .alu_operation (alu_operation),
    .alu_result    (alu_result),
    .alu_carry     (alu_carry),
    .done          (done),
    .error         (error),
    .carry_flag    (carry_flag),
    .zero_flag     (zero_flag),
    .rd_sel        (rd_sel),
    .rd_data       (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) cycleCount++;

  // Behavioural ALU; bit 8 is deliberately noisy for SUB/MUL so a sequencer
  // that forgets to clear carry on non-ADD ops is caught.
  logic [15:0] aluFull;
  always_comb begin
    aluFull = '0;
    case (alu_operation)
      3'd0: aluFull = {8'd0, alu_operand1} + {8'd0, alu_operand2};
      3'd1: aluFull = {8'd0, alu_operand1} - {8'd0, alu_operand2};
      3'd2: aluFull = {8'd0, alu_operand1} * {8'd0, alu_operand2};
      3'd3: aluFull = (alu_operand2 == 8'd0) ? 16'h01FF : {8'd0, alu_operand1 / alu_operand2};
      3'd4: aluFull = {8'd0, alu_operand1 & alu_operand2};
      3'd5: aluFull = {8'd0, alu_operand1 | alu_operand2};
      3'd6: aluFull = {8'd0, alu_operand1 ^ alu_operand2};
      default: aluFull = 16'h0000;
    endcase
  end
  assign alu_result = aluFull[7:0];
  assign alu_carry  = aluFull[8];

  // Reference model: on accept it works out the whole instruction's effect,
  // applies it one edge later and expects the retire pulse for one cycle.
  logic [7:0] mRegs [4];
  logic       mCarry, mZero, mDone, mErr;
  logic [7:0] mOp1, mOp2;
  logic [2:0] mOpn;
  int         busy;
  logic       pWrite, pFlags, pErr, pCarry, pZero;
  logic [1:0] pDst;
  logic [7:0] pVal;

  always @(posedge clk or posedge rst) begin : model
    int a, b, v;
    logic [3:0] opc;
    if (rst) begin
      for (int i = 0; i < 4; i++) mRegs[i] = 8'd0;
      mCarry = 0; mZero = 0; mDone = 0; mErr = 0;
      mOp1 = 0; mOp2 = 0; mOpn = 0;
      busy = 0;
    end else begin
      mDone = 0;
      mErr  = 0;
      if (busy == 2) begin
        if (pWrite) mRegs[pDst] = pVal;
        if (pFlags) begin
          mZero  = pZero;
          mCarry = pCarry;
        end
        mDone = !pErr;
        mErr  = pErr;
        busy  = 1;
      end else if (busy == 1) begin
        busy = 0;
      end else if (instr_valid) begin
        opc  = instr[15:12];
        pDst = instr[11:10];
        a    = int'(mRegs[instr[9:8]]);
        b    = int'(mRegs[instr[7:6]]);
        mOp1 = mRegs[instr[9:8]];
        mOp2 = mRegs[instr[7:6]];
        mOpn = opc[2:0];
        pWrite = 1; pFlags = 1; pErr = 0; pCarry = 0; v = 0;
        case (opc)
          4'h0: begin v = a + b; pCarry = (v > 255); end
          4'h1: v = a - b + 256;
          4'h2: v = a * b;
          4'h3: if (b == 0) begin pErr = 1; pWrite = 0; pFlags = 0; end else v = a / b;
          4'h4: v = a & b;
          4'h5: v = a | b;
          4'h6: v = a ^ b;
          4'h8: begin v = int'(instr[7:0]); pFlags = 0; end
          default: begin pErr = 1; pWrite = 0; pFlags = 0; end
        endcase
        v     = v % 256;
        pVal  = v[7:0];
        pZero = (v == 0);
        busy  = 2;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("instr_ready", 16'(instr_ready), 16'(busy == 0));
    checkOutput("done", 16'(done), 16'(mDone));
    checkOutput("error", 16'(error), 16'(mErr));
    checkOutput("carry_flag", 16'(carry_flag), 16'(mCarry));
    checkOutput("zero_flag", 16'(zero_flag), 16'(mZero));
    checkOutput("rd_data", 16'(rd_data), 16'(mRegs[rd_sel]));
    checkOutput("alu_operand1", 16'(alu_operand1), 16'(mOp1));
    checkOutput("alu_operand2", 16'(alu_operand2), 16'(mOp2));
    checkOutput("alu_operation", 16'(alu_operation), 16'(mOpn));
  end

  // Offers one instruction and returns #1 after the edge that accepted it.
  task automatic applyStimulus(input logic [15:0] ins);
    int waitCyc = 0;
    instr       = ins;
    instr_valid = 1'b1;
    while (!instr_ready && waitCyc < 20) begin
      @(negedge clk);
      waitCyc++;
    end
    if (!instr_ready) begin
      checkOutput("accept_timeout", 16'(instr_ready), 16'd1);
    end
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  function automatic logic [15:0] mkR(input logic [3:0] op, input logic [1:0] d,
                                      input logic [1:0] s1, input logic [1:0] s2);
    return {op, d, s1, s2, 6'd0};
  endfunction

  function automatic logic [15:0] mkLdi(input logic [1:0] d, input logic [7:0] imm);
    return {4'h8, d, 2'b00, imm};
  endfunction

  task automatic peekReg(input string name, input logic [1:0] r, input logic [7:0] expected);
    rd_sel = r;
    #1;
    checkOutput(name, 16'(rd_data), 16'(expected));
  endtask

  task automatic stepRetire();
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int acc [4];
    rst = 1'b1;
    instr_valid = 1'b0;
    instr = 16'h0000;
    rd_sel = 2'd0;
    #22;
    rst = 1'b0;

    checkOutput("reset_ready", 16'(instr_ready), 16'd1);
    checkOutput("reset_done", 16'(done), 16'd0);
    checkOutput("reset_flags", 16'({carry_flag, zero_flag}), 16'd0);
    peekReg("reset_r2", 2'd2, 8'h00);

    applyStimulus(mkLdi(2'd1, 8'hC8));
    stepRetire();
    stepRetire();
    applyStimulus(mkLdi(2'd2, 8'h64));
    stepRetire();
    stepRetire();
    applyStimulus(mkR(4'h0, 2'd3, 2'd1, 2'd2));
    checkOutput("add_done_exec", 16'(done), 16'd0);
    stepRetire();
    checkOutput("add_done", 16'(done), 16'd1);
    checkOutput("add_carry", 16'(carry_flag), 16'd1);
    checkOutput("add_zero", 16'(zero_flag), 16'd0);
    peekReg("add_r3", 2'd3, 8'h2C);
    stepRetire();

    applyStimulus(mkR(4'h1, 2'd0, 2'd1, 2'd1));
    stepRetire();
    checkOutput("sub_zero", 16'(zero_flag), 16'd1);
    checkOutput("sub_carry", 16'(carry_flag), 16'd0);
    peekReg("sub_r0", 2'd0, 8'h00);
    stepRetire();

    applyStimulus(mkR(4'h3, 2'd3, 2'd1, 2'd0));
    stepRetire();
    checkOutput("div0_error", 16'(error), 16'd1);
    checkOutput("div0_done", 16'(done), 16'd0);
    checkOutput("div0_flags", 16'({carry_flag, zero_flag}), 16'b01);
    peekReg("div0_r3", 2'd3, 8'h2C);
    stepRetire();

    applyStimulus(mkR(4'h7, 2'd2, 2'd1, 2'd1));
    stepRetire();
    checkOutput("ill7_error", 16'(error), 16'd1);
    stepRetire();
    checkOutput("ill7_ready", 16'(instr_ready), 16'd1);
    applyStimulus(mkR(4'hF, 2'd2, 2'd1, 2'd1));
    stepRetire();
    checkOutput("illF_error", 16'(error), 16'd1);
    peekReg("illF_r2", 2'd2, 8'h64);
    stepRetire();
    checkOutput("illF_ready", 16'(instr_ready), 16'd1);

    // Back-to-back stream with instr_valid never dropped.
    instr_valid = 1'b1;
    instr = mkLdi(2'd1, 8'h10);
    for (int k = 0; k < 4; k++) begin
      int w = 0;
      while (!instr_ready && w < 20) begin
        @(negedge clk);
        w++;
      end
      @(posedge clk);
      acc[k] = cycleCount;
      #1;
      case (k)
        0: instr = mkLdi(2'd2, 8'h11);
        1: instr = mkR(4'h2, 2'd1, 2'd1, 2'd2);
        default: instr = mkLdi(2'd0, 8'h55);
      endcase
    end
    instr_valid = 1'b0;
    for (int k = 1; k < 4; k++) begin
      checkOutput("b2b_spacing", 16'(acc[k] - acc[k-1]), 16'd3);
    end
    stepRetire();
    stepRetire();
    peekReg("mul_r1", 2'd1, 8'h10);
    peekReg("b2b_r0", 2'd0, 8'h55);

    // Reset while XOR is in EXEC: nothing may retire.
    applyStimulus(mkR(4'h6, 2'd2, 2'd1, 2'd1));
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_done", 16'(done), 16'd0);
    checkOutput("abort_error", 16'(error), 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("abort_ready", 16'(instr_ready), 16'd1);
    for (int r = 0; r < 4; r++) begin
      peekReg("abort_reg", 2'(r), 8'h00);
    end

    // Randomized stream checked against the model by the compare process.
    for (int n = 0; n < 200; n++) begin
      logic [3:0] op;
      logic [15:0] ins;
      int gap;
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) op = 4'h8;
      ins = 16'($urandom);
      ins[15:12] = op;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk);
        #1;
        rd_sel = 2'($urandom_range(0, 3));
      end
      applyStimulus(ins);
      rd_sel = 2'($urandom_range(0, 3));
    end
    stepRetire();
    stepRetire();
    stepRetire();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
